ms6205_display_responder: RTL

//  Display-side responder for the MS6205 character-display write interface.

---
 rtl/ms6205_display_responder_if.sv | 27 ++
 rtl/ms6205_display_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ms6205_display_responder_if.sv
// MS6205 display write bus plus scan-out read port, grouped for the responder.
// Pure wiring, no latency of its own.
// Pacing is carried by 'ready'; the initiator must not strobe while it is low.
interface ms6205_display_responder_if;
    logic [7:0] bus_data;
    logic       write_addr_n;
    logic       write_data_n;
    logic       marker;
    logic       ready;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic [7:0] cursor;
    logic       marker_valid;
    logic       protocol_err;

    // Initiator side: drives strobes, data byte, marker and scan-out address.
    modport master (
        output bus_data, write_addr_n, write_data_n, marker, rd_addr,
        input  ready, rd_data, cursor, marker_valid, protocol_err
    );

    // Display side: the responder.
    modport slave (
        input  bus_data, write_addr_n, write_data_n, marker, rd_addr,
        output ready, rd_data, cursor, marker_valid, protocol_err
    );
endinterface

// File: rtl/ms6205_display_responder.sv
// MS6205 display responder: synchronises write strobes, stores chars in a screen buffer, tracks cursor.
// Strobe acts on the 3rd clk after the pin falls; rd_data has 1-cycle latency.
// ready drops for BUSY_CYCLES after each accepted strobe and during the post-reset clear sweep.
module ms6205_display_responder #(
    parameter int         NUM_CHARS     = 160,
    parameter int         BUSY_CYCLES   = 8,
    parameter bit         DATA_INVERTED = 1'b1,
    parameter bit         AUTO_INC      = 1'b1,
    parameter logic [7:0] BLANK_CHAR    = 8'h20
) (
    input  logic                         clk,
    input  logic                         rst,
    ms6205_display_responder_if.slave    bus
);
    localparam int AW = $clog2(NUM_CHARS);
    localparam int CW = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
    localparam logic [7:0]    LAST_ADDR = 8'(NUM_CHARS - 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_CHARS - 1);
    localparam logic [CW-1:0] BUSY_LOAD = CW'(BUSY_CYCLES - 1);

    typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_BUSY} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cursor_q, cursor_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] clear_idx_q, clear_idx_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          marker_q;
    logic [7:0]    rd_data_q;

    logic          addr_s1, addr_s2, addr_prev;
    logic          data_s1, data_s2, data_prev;
    logic          addr_fall, data_fall;

    logic [7:0]    mem [NUM_CHARS];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    // Two-flop synchronisers plus a history flop for falling-edge detection; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_s1   <= 1'b1;
            addr_s2   <= 1'b1;
            addr_prev <= 1'b1;
            data_s1   <= 1'b1;
            data_s2   <= 1'b1;
            data_prev <= 1'b1;
        end else begin
            addr_s1   <= bus.write_addr_n;
            addr_s2   <= addr_s1;
            addr_prev <= addr_s2;
            data_s1   <= bus.write_data_n;
            data_s2   <= data_s1;
            data_prev <= data_s2;
        end
    end

    assign addr_fall = addr_prev & ~addr_s2;
    assign data_fall = data_prev & ~data_s2;

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            cursor_q    <= 8'd0;
            cnt_q       <= '0;
            clear_idx_q <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            cnt_q       <= cnt_d;
            clear_idx_q <= clear_idx_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic: clear sweep, strobe decode, busy pacing and error capture.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        cnt_d       = cnt_q;
        clear_idx_d = clear_idx_q;
        ready_d     = ready_q;
        err_d       = err_q;
        mem_we      = 1'b0;
        mem_waddr   = clear_idx_q;
        mem_wdata   = BLANK_CHAR;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (addr_fall || data_fall) err_d = 1'b1;
                if (clear_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    clear_idx_d = clear_idx_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (addr_fall && data_fall) begin
                    // Ambiguous request: apply neither strobe.
                    err_d = 1'b1;
                end else if (addr_fall) begin
                    cursor_d = bus.bus_data;
                    cnt_d    = BUSY_LOAD;
                    ready_d  = 1'b0;
                    state_d  = ST_BUSY;
                end else if (data_fall) begin
                    if (cursor_q <= LAST_ADDR) begin
                        mem_we    = 1'b1;
                        mem_waddr = cursor_q[AW-1:0];
                        mem_wdata = DATA_INVERTED ? ~bus.bus_data : bus.bus_data;
                        if (AUTO_INC)
                            cursor_d = (cursor_q == LAST_ADDR) ? 8'd0 : cursor_q + 8'd1;
                    end else begin
                        // Off-screen cursor: no store, no advance, but still pace the initiator.
                        err_d = 1'b1;
                    end
                    cnt_d   = BUSY_LOAD;
                    ready_d = 1'b0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (addr_fall || data_fall) err_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Screen buffer write port; contents are refreshed by the clear sweep, not by reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Registered scan-out read and marker copy; a same-cycle write returns the old cell value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= BLANK_CHAR;
            marker_q  <= 1'b0;
        end else begin
            rd_data_q <= (bus.rd_addr <= LAST_ADDR) ? mem[bus.rd_addr[AW-1:0]] : BLANK_CHAR;
            marker_q  <= bus.marker;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.cursor       = cursor_q;
    assign bus.protocol_err = err_q;
    assign bus.rd_data      = rd_data_q;
    assign bus.marker_valid = marker_q;
endmodule
